// File: rtl/dca_mru_seq_pkg.sv
// Shared definitions for the DCA MRU sequencer: opcode bit indices, LSU
// instruction formats, matrix/block info layouts and FSM encodings.
package dca_mru_seq_pkg;

    localparam int BW_DCA_MRU_OPCODE          = 12;
    localparam int BW_DCA_MATRIX_INFO_ALIGNED = 32;
    localparam int BW_DCA_BLOCK_INFO          = 32;
    localparam int BW_DCA_LSU_OPCODE          = 2;
    localparam int BW_DCA_MATRIX_LSU_INST     = BW_DCA_BLOCK_INFO + BW_DCA_LSU_OPCODE;
    localparam int BW_BLOCKED_STEP_INST       = 1 + BW_DCA_MRU_OPCODE;

    // Opcode bit indices; bits [11:9] carry the compute operation itself.
    localparam int DCA_MRU_OPCODE_INDEX_LSU_REQ_BASE       = 0;
    localparam int DCA_MRU_OPCODE_INDEX_TRANSPOSE_SRC_BASE = 4;
    localparam int DCA_MRU_OPCODE_INDEX_TRANSPOSE_DST      = 8;

    localparam logic [BW_DCA_LSU_OPCODE-1:0] OPCODE_READ  = 2'b01;
    localparam logic [BW_DCA_LSU_OPCODE-1:0] OPCODE_WRITE = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mru_state_e;

    typedef struct packed {
        logic [15:0] base_addr;
        logic [7:0]  rows;
        logic [7:0]  cols;
    } matrix_info_t;

    typedef struct packed {
        logic [15:0] base_addr;
        logic [7:0]  blk_y;
        logic [7:0]  blk_x;
    } block_info_t;

    // Instruction layout: {opcode, dst_info, src_info[NUM_SRC-1] .. src_info[0]}.
    function automatic int inst_src_lsb(input int idx);
        return idx * BW_DCA_MATRIX_INFO_ALIGNED;
    endfunction

    function automatic int inst_dst_lsb(input int num_src);
        return num_src * BW_DCA_MATRIX_INFO_ALIGNED;
    endfunction

    function automatic int inst_opcode_lsb(input int num_src);
        return (num_src + 1) * BW_DCA_MATRIX_INFO_ALIGNED;
    endfunction

    // Index of the last block along one dimension; an empty dimension is one block.
    function automatic logic [7:0] blk_last_idx(input logic [7:0] dim, input int para);
        logic [31:0] d;
        d = {24'd0, dim};
        return (dim == 8'd0) ? 8'd0 : 8'((d - 32'd1) / 32'(para));
    endfunction

endpackage

// File: rtl/dca_matrix_splitter.sv
// Walks a matrix in MATRIX_SIZE_PARA-sized blocks. iterate_i advances the
// fast axis (y when col_first_i, else x); go_next_base_i wraps the fast axis
// and advances the slow axis, wrapping to (0,0) after the last block.
// is_last_x_o flags the fast axis at its last block.
module dca_matrix_splitter
    import dca_mru_seq_pkg::*;
#(
    parameter int MATRIX_SIZE_PARA = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         init_i,
    input  logic         col_first_i,
    input  matrix_info_t info_i,
    input  logic         iterate_i,
    input  logic         go_next_base_i,
    output block_info_t  block_info_o,
    output logic         is_last_x_o,
    output logic         is_last_element_o
);

    logic [7:0] blk_x_q, blk_x_d, blk_y_q, blk_y_d;
    logic [7:0] last_x, last_y;
    logic       inner_last, outer_last;

    // Block position bookkeeping for the current walk order.
    always_comb begin
        last_x     = blk_last_idx(info_i.cols, MATRIX_SIZE_PARA);
        last_y     = blk_last_idx(info_i.rows, MATRIX_SIZE_PARA);
        inner_last = col_first_i ? (blk_y_q == last_y) : (blk_x_q == last_x);
        outer_last = col_first_i ? (blk_x_q == last_x) : (blk_y_q == last_y);
    end

    // Next block index.
    always_comb begin
        blk_x_d = blk_x_q;
        blk_y_d = blk_y_q;
        if (clear_i || init_i) begin
            blk_x_d = '0;
            blk_y_d = '0;
        end else if (go_next_base_i) begin
            if (col_first_i) begin
                blk_y_d = '0;
                blk_x_d = outer_last ? 8'd0 : blk_x_q + 8'd1;
            end else begin
                blk_x_d = '0;
                blk_y_d = outer_last ? 8'd0 : blk_y_q + 8'd1;
            end
        end else if (iterate_i) begin
            if (col_first_i) begin
                blk_y_d = blk_y_q + 8'd1;
            end else begin
                blk_x_d = blk_x_q + 8'd1;
            end
        end
    end

    // Block index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_x_q <= '0;
            blk_y_q <= '0;
        end else begin
            blk_x_q <= blk_x_d;
            blk_y_q <= blk_y_d;
        end
    end

    assign block_info_o      = '{base_addr: info_i.base_addr, blk_y: blk_y_q, blk_x: blk_x_q};
    assign is_last_x_o       = inner_last;
    assign is_last_element_o = inner_last & outer_last;

endmodule

// File: rtl/dca_mru_credit_counter.sv
// Outstanding-load credit counter: +1 per issued load step, -1 per consumed
// block set, saturating at 0 and CREDIT_DEPTH.
module dca_mru_credit_counter #(
    parameter  int CREDIT_DEPTH = 2,
    localparam int CW           = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic credit_avail_o
);

    logic [CW-1:0] credit_q, credit_d;

    // Next credit value; a simultaneous inc and dec cancels out.
    always_comb begin
        // NOTE: default first so every path assigns credit_d and no latch is inferred.
        credit_d = credit_q;
        if (clear_i) begin
            credit_d = '0;
        end else if (inc_i && !dec_i && (credit_q < CW'(CREDIT_DEPTH))) begin
            credit_d = credit_q + CW'(1);
        end else if (dec_i && !inc_i && (credit_q != '0)) begin
            credit_d = credit_q - CW'(1);
        end
    end

    // Credit register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (rst) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign credit_avail_o = (credit_q < CW'(CREDIT_DEPTH));

endmodule

// File: rtl/dca_mru_sequencer.sv
// MRU instruction sequencer: latches one instruction, then per block step
// issues a load per active source, one compute step and one destination
// store, all in the same cycle, throttled by an outstanding-load credit.
// Optional macro DCA_MRU_SEQUENCER_PERF_EN adds step/stall counters.
module dca_mru_sequencer
    import dca_mru_seq_pkg::*;
#(
    parameter  int MATRIX_SIZE_PARA = 8,
    parameter  int NUM_SRC          = 2,
    parameter  int CREDIT_DEPTH     = 2,
    localparam int BW_INST          = BW_DCA_MRU_OPCODE + (NUM_SRC + 1) * BW_DCA_MATRIX_INFO_ALIGNED
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      clear,
    input  logic                                      enable,
    output logic                                      busy,
    input  logic                                      inst_valid,
    input  logic [BW_INST-1:0]                        inst,
    output logic                                      inst_ready,
    output logic                                      inst_done,
    output logic [NUM_SRC-1:0]                        ld_req_valid,
    input  logic [NUM_SRC-1:0]                        ld_req_ready,
    output logic [NUM_SRC*BW_DCA_MATRIX_LSU_INST-1:0] ld_req_inst,
    input  logic                                      ld_consumed,
    output logic                                      step_valid,
    input  logic                                      step_ready,
    output logic [BW_BLOCKED_STEP_INST-1:0]           step_inst,
    output logic                                      st_req_valid,
    input  logic                                      st_req_ready,
    output logic [BW_DCA_MATRIX_LSU_INST-1:0]         st_req_inst
`ifdef DCA_MRU_SEQUENCER_PERF_EN
    ,
    output logic [31:0]                               perf_step_count,
    output logic [31:0]                               perf_stall_lsu,
    output logic [31:0]                               perf_stall_credit
`endif
);

    localparam int IW      = BW_DCA_MATRIX_INFO_ALIGNED;
    localparam int LW      = BW_DCA_MATRIX_LSU_INST;
    localparam int DST_LSB = inst_dst_lsb(NUM_SRC);
    localparam int OPC_LSB = inst_opcode_lsb(NUM_SRC);

    mru_state_e                   state_q, state_d;
    logic [BW_INST-1:0]           inst_q;
    logic [BW_DCA_MRU_OPCODE-1:0] opcode;
    logic [NUM_SRC-1:0]           src_active, src_transpose;
    logic                         accept, fire, readies_ok, credit_ok, credit_avail;
    logic                         dst_last_element;
    matrix_info_t                 mat_info [NUM_SRC+1];
    block_info_t                  blk_info [NUM_SRC+1];
    logic [NUM_SRC:0]             is_last_x, is_last_element;
    logic [NUM_SRC:0]             split_iterate, split_go_next, split_col_first;

    // Decode the registered instruction and derive per-splitter controls.
    always_comb begin
        opcode        = inst_q[OPC_LSB +: BW_DCA_MRU_OPCODE];
        src_active    = opcode[DCA_MRU_OPCODE_INDEX_LSU_REQ_BASE +: NUM_SRC];
        src_transpose = opcode[DCA_MRU_OPCODE_INDEX_TRANSPOSE_SRC_BASE +: NUM_SRC];
        for (int i = 0; i < NUM_SRC; i++) begin
            mat_info[i]        = inst_q[inst_src_lsb(i) +: IW];
            split_iterate[i]   = fire & src_active[i];
            split_go_next[i]   = split_iterate[i] & is_last_x[i];
            split_col_first[i] = ~src_transpose[i];
        end
        mat_info[NUM_SRC]        = inst_q[DST_LSB +: IW];
        split_iterate[NUM_SRC]   = fire;
        split_go_next[NUM_SRC]   = fire & is_last_x[NUM_SRC];
        split_col_first[NUM_SRC] = ~opcode[DCA_MRU_OPCODE_INDEX_TRANSPOSE_DST];
    end

    // FSM next state and request outputs; every request fires together.
    always_comb begin
        state_d          = state_q;
        busy             = 1'b0;
        inst_ready       = 1'b0;
        accept           = 1'b0;
        fire             = 1'b0;
        dst_last_element = is_last_element[NUM_SRC];
        readies_ok       = step_ready & st_req_ready & (&(ld_req_ready | ~src_active));
        credit_ok        = credit_avail | ~(|src_active);
        case (state_q)
            IDLE: begin
                inst_ready = enable;
                accept     = enable & inst_valid;
                if (accept) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                fire = enable & readies_ok & credit_ok;
                if (fire && dst_last_element) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;

        step_valid   = fire;
        st_req_valid = fire;
        ld_req_valid = {NUM_SRC{fire}} & src_active;
        inst_done    = fire & dst_last_element & ~clear;
        step_inst    = {dst_last_element, opcode};
        st_req_inst  = {blk_info[NUM_SRC], OPCODE_WRITE};
        ld_req_inst  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ld_req_inst[i*LW +: LW] = {blk_info[i], OPCODE_READ};
        end
    end

    // State and instruction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            // NOTE: the instruction register is reset so decode never sees X after reset.
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept && !clear) inst_q <= inst;
        end
    end

    for (genvar g = 0; g <= NUM_SRC; g++) begin : g_split
        dca_matrix_splitter #(
            .MATRIX_SIZE_PARA (MATRIX_SIZE_PARA)
        ) u_split (
            .clk               (clk),
            .rst               (rst),
            .clear_i           (clear),
            .init_i            (accept & ~clear),
            .col_first_i       (split_col_first[g]),
            .info_i            (mat_info[g]),
            .iterate_i         (split_iterate[g]),
            .go_next_base_i    (split_go_next[g]),
            .block_info_o      (blk_info[g]),
            .is_last_x_o       (is_last_x[g]),
            .is_last_element_o (is_last_element[g])
        );
    end

    dca_mru_credit_counter #(
        .CREDIT_DEPTH (CREDIT_DEPTH)
    ) u_credit (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (clear),
        .inc_i          (fire & (|src_active)),
        .dec_i          (ld_consumed & enable),
        .credit_avail_o (credit_avail)
    );

`ifdef DCA_MRU_SEQUENCER_PERF_EN
    logic [31:0] perf_step_q, perf_lsu_q, perf_credit_q;
    logic        stall_lsu, stall_credit;

    assign stall_lsu    = busy & enable & ~readies_ok;
    assign stall_credit = busy & enable & readies_ok & ~credit_ok;

    // Saturating performance counters, restarted per instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_step_q   <= '0;
            perf_lsu_q    <= '0;
            perf_credit_q <= '0;
        end else if (clear || accept) begin
            perf_step_q   <= '0;
            perf_lsu_q    <= '0;
            perf_credit_q <= '0;
        end else begin
            if (fire && (perf_step_q != '1))           perf_step_q   <= perf_step_q + 32'd1;
            if (stall_lsu && (perf_lsu_q != '1))       perf_lsu_q    <= perf_lsu_q + 32'd1;
            if (stall_credit && (perf_credit_q != '1)) perf_credit_q <= perf_credit_q + 32'd1;
        end
    end

    assign perf_step_count   = perf_step_q;
    assign perf_stall_lsu    = perf_lsu_q;
    assign perf_stall_credit = perf_credit_q;
`endif

endmodule

// File: doc/dca_mru_sequencer.md
Name: dca_mru_sequencer

Overview:
- Next-generation matrix-unit (MRU) instruction sequencer for the DCA datapath.
- Accepts one MRU instruction carrying up to NUM_SRC source matrices and one destination matrix, and splits each matrix into MATRIX_SIZE_PARA-sized blocks.
- Per block step it issues one load request per active source, one step instruction to the compute unit and one store request for the destination.
- Per-source transpose selection, a registered instruction and a CREDIT_DEPTH-deep outstanding-load limiter generalise the current single-source controller.

Parameters:
MATRIX_SIZE_PARA, 8, block edge length passed to every splitter
NUM_SRC, 2, number of source load channels (1..4)
CREDIT_DEPTH, 2, max load steps issued ahead of compute consumption (1..7)
BW_INST, `BW_DCA_MRU_OPCODE+(NUM_SRC+1)*`BW_DCA_MATRIX_INFO_ALIGNED, instruction width (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
clear  in  1  synchronous abort: return to IDLE, credits 0, splitters cleared
enable  in  1  global advance qualifier; when low, no state changes
busy  out  1  high in RUN
inst_valid  in  1  instruction offered
inst  in  BW_INST  {opcode, dst_info, src_info[NUM_SRC-1]..src_info[0]}
inst_ready  out  1  = IDLE & enable
inst_done  out  1  one-cycle pulse on the last step fire
ld_req_valid  out  NUM_SRC  per-source load request valid
ld_req_ready  in  NUM_SRC  per-source LSU ready
ld_req_inst  out  NUM_SRC*`BW_DCA_MATRIX_LSU_INST  {block_info, OPCODE_READ} per source
ld_consumed  in  1  compute unit released one loaded block set
step_valid  out  1  step instruction valid
step_ready  in  1  compute unit ready
step_inst  out  BW_BLOCKED_STEP_INST  {is_last_step, opcode}
st_req_valid  out  1  store request valid
st_req_ready  in  1  store LSU ready
st_req_inst  out  `BW_DCA_MATRIX_LSU_INST  {dst block_info, OPCODE_WRITE}

Behaviour:
- Reset: FSM IDLE, instruction register 0, credit 0; all valids, busy, inst_done = 0.
- FSM IDLE->RUN on inst_valid & inst_ready. The instruction is latched that cycle and all splitters are initialised. RUN->IDLE on the step fire whose dst is_last_element = 1.
- Active source i: opcode bit LSU_REQ[i]. Inactive sources hold ld_req_valid[i]=0, are not iterated and do not gate steps.
- go = RUN & enable & step_ready & st_req_ready & AND over active i of ld_req_ready[i] & (credit<CREDIT_DEPTH, or no source active).
- step_valid = st_req_valid = go. ld_req_valid[i] = go & active[i]. All requests fire in the same cycle; there are no partial fires.
- fire = go; no valid waits on its own ready externally, since go already includes all readies.
- On fire: iterate every active source splitter and the dst splitter.
  - Source i go_next_base = fire & is_last_x of source i.
  - Dst go_next_base = fire & dst is_last_x.
- Walk order:
  - Source i col-first = ~TRANSPOSE_SRC[i].
  - Dst col-first = ~TRANSPOSE_DST.
- is_last_step = dst is_last_element. Sources wrap independently and have no completion role.
- Credit counter:
  - +1 on a fire with any active source; -1 on ld_consumed.
  - Both in the same cycle: unchanged.
  - ld_consumed at credit 0: ignored, and the counter stays 0.
  - The counter persists across instructions and is zeroed only by rst or clear.
- Latency: the first step fires no earlier than the cycle after acceptance. Steady state is one step per cycle when all readies are high and credit is available.
- clear has priority over every other event in the same cycle.
- rst mid-RUN: immediate IDLE. Any in-flight LSU requests are abandoned with no completion signalled.
- A single-block matrix (dims ≤ MATRIX_SIZE_PARA) fires exactly one step, with is_last_step = 1 and inst_done pulsing.

Optional Feature:
DCA_MRU_SEQUENCER_PERF_EN
- Defined: adds outputs perf_step_count[31:0], perf_stall_lsu[31:0] and perf_stall_credit[31:0].
  - perf_stall_lsu counts RUN cycles with no fire due to ready deassertion.
  - perf_stall_credit counts RUN cycles with no fire due to exhausted credit.
  - All three counters reset on rst or clear, reset on acceptance of a new instruction, and saturate at all-ones.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dca_mru_seq_pkg:
  - opcode bit indices DCA_MRU_OPCODE_INDEX_LSU_REQ_BASE, TRANSPOSE_SRC_BASE, TRANSPOSE_DST;
  - FSM encodings IDLE=0, RUN=1;
  - instruction field offsets as a function of NUM_SRC.
- Existing matrix splitter instantiated NUM_SRC+1 times in a generate loop.
- One natural sub-module: dca_mru_credit_counter (saturating up/down counter, parameter CREDIT_DEPTH, outputs credit_avail).

Test Plan:
- 16x16 dst, two active 16x16 sources, all readies high, MATRIX_SIZE_PARA=8 -> 4 consecutive fires, is_last_step only on the 4th, inst_done pulses once, busy drops the next cycle.
- CREDIT_DEPTH=2, ld_consumed held low -> exactly 2 fires, then step_valid stays 0. A single ld_consumed pulse -> exactly 1 further fire.
- Source 1 inactive, ld_req_ready[1]=0 -> steps still fire and ld_req_valid[1] never asserts.
- TRANSPOSE_SRC[0]=1 on a 16x8 source -> block_info order is row-first (x advances first), versus column-first for source 1.
- Deassert st_req_ready for 3 cycles mid-run -> no valids for 3 cycles and no splitter advance; resumes on the same block_info.
- clear asserted mid-run (after 2 of 4 steps) -> next cycle IDLE, inst_ready=1, credit 0, no inst_done. A new instruction restarts at block (0,0).
